// File: rtl/playseq_pkg.sv
// Shared definitions for the PlaySeq game: state encoding, LFSR polynomial and default seed.
package playseq_pkg;

  typedef enum logic [4:0] {
    INICIAL     = 5'd0,
    GERA        = 5'd1,
    MOSTRA      = 5'd2,
    PAUSA       = 5'd3,
    ESPERA      = 5'd4,
    COMPARA     = 5'd5,
    FIM_RODADA  = 5'd6,
    ESCREVE     = 5'd7,
    FIM_GANHOU  = 5'd8,
    FIM_PERDEU  = 5'd9,
    FIM_TIMEOUT = 5'd10
  } estado_t;

  localparam logic [15:0] SEMENTE_PADRAO = 16'hACE1;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_passo(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/playseq_ram_param.sv
// Sequence memory: PROF entries of one-hot moves, synchronous write, asynchronous read.
module playseq_ram_param #(
  parameter int PROF = 16,
  parameter int LARG = 4
) (
  input  logic                    clock,
  input  logic                    we,
  input  logic [$clog2(PROF)-1:0] waddr,
  input  logic [LARG-1:0]         wdata,
  input  logic [$clog2(PROF)-1:0] raddr,
  output logic [LARG-1:0]         rdata
);

  logic [LARG-1:0] mem [PROF];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/playseq_jogo_param.sv
// Simon-style game core: LFSR sequence generation, preview, player echo, append mode,
// move timeout and saturating win/loss scoreboards.
module playseq_jogo_param
  import playseq_pkg::*;
#(
  parameter int N_BOTOES  = 4,
  parameter int PROF      = 16,
  parameter int T_TIMEOUT = 5000,
  parameter int T_LED     = 1000,
  parameter int W_PLACAR  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    jogar,
  input  logic [N_BOTOES-1:0]     botoes,
  input  logic [1:0]              nivel,
  input  logic                    modo_escrita,
  input  logic                    ignora_timeout,
  input  logic [15:0]             semente,
  input  logic                    zera_placar,
  output logic [N_BOTOES-1:0]     leds,
  output logic                    ganhou,
  output logic                    perdeu,
  output logic                    timeout,
  output logic                    pronto,
  output logic [W_PLACAR-1:0]     vitorias,
  output logic [W_PLACAR-1:0]     derrotas,
  output logic [4:0]              db_estado,
  output logic [$clog2(PROF)-1:0] db_rodada,
  output logic [N_BOTOES-1:0]     db_esperado
);

  localparam int NB = $clog2(N_BOTOES);
  localparam int WP = $clog2(PROF);
  localparam int TW = $clog2(T_TIMEOUT + 1);
  localparam int LW = $clog2(T_LED + 1);

  estado_t             state_reg, state_next;
  logic [WP-1:0]       r_reg, r_next, e_reg, e_next, g_reg, g_next;
  logic [15:0]         lfsr_reg, lfsr_next;
  logic [1:0]          nivel_reg, nivel_next;
  logic                modo_reg, modo_next;
  logic [TW-1:0]       timer_reg, timer_next;
  logic [LW-1:0]       led_cnt_reg, led_cnt_next;
  logic                ant_reg;
  logic [N_BOTOES-1:0] move_reg;
  logic [W_PLACAR-1:0] vitorias_reg, derrotas_reg;

  logic                we;
  logic [WP-1:0]       waddr;
  logic [N_BOTOES-1:0] wdata, esperado, lfsr_onehot;
  logic                valid, timer_fim, led_fim;
  logic [WP:0]         alvo, r_mais;

  playseq_ram_param #(.PROF(PROF), .LARG(N_BOTOES)) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (e_reg),
    .rdata (esperado)
  );

  // A move counts only on the rising edge of "any button"; holding a button never repeats it.
  assign valid       = (|botoes) && !ant_reg;
  assign timer_fim   = !ignora_timeout && (timer_reg == TW'(T_TIMEOUT - 1));
  assign led_fim     = (led_cnt_reg == LW'(T_LED - 1));
  assign lfsr_onehot = {{(N_BOTOES-1){1'b0}}, 1'b1} << lfsr_reg[NB-1:0];
  assign alvo        = (WP+1)'((int'(nivel_reg) + 1) * (PROF / 4));
  assign r_mais      = {1'b0, r_reg} + (WP+1)'(1);

  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    e_next     = e_reg;
    g_next     = g_reg;
    lfsr_next  = lfsr_reg;
    nivel_next = nivel_reg;
    modo_next  = modo_reg;
    we         = 1'b0;
    waddr      = g_reg;
    wdata      = lfsr_onehot;
    leds       = '0;
    case (state_reg)
      INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
        if (jogar) begin
          state_next = GERA;
          nivel_next = nivel;
          modo_next  = modo_escrita;
          lfsr_next  = (semente == 16'd0) ? SEMENTE_PADRAO : semente;
          g_next     = '0;
          r_next     = '0;
          e_next     = '0;
        end
      end
      GERA: begin
        we        = !modo_reg || (g_reg == '0);
        lfsr_next = lfsr_passo(lfsr_reg);
        g_next    = g_reg + WP'(1);
        if (g_reg == WP'(PROF - 1)) state_next = MOSTRA;
      end
      MOSTRA: begin
        leds = esperado;
        if (led_fim) state_next = PAUSA;
      end
      PAUSA: begin
        if (led_fim) begin
          if (e_reg < r_reg) begin
            e_next     = e_reg + WP'(1);
            state_next = MOSTRA;
          end else begin
            e_next     = '0;
            state_next = ESPERA;
          end
        end
      end
      ESPERA: begin
        leds = botoes;
        if (valid)          state_next = COMPARA;
        else if (timer_fim) state_next = FIM_TIMEOUT;
      end
      COMPARA: begin
        // Stored moves are one-hot, so a multi-bit press always lands here as a mismatch.
        if (move_reg != esperado) begin
          state_next = FIM_PERDEU;
        end else if (e_reg < r_reg) begin
          e_next     = e_reg + WP'(1);
          state_next = ESPERA;
        end else begin
          state_next = FIM_RODADA;
        end
      end
      FIM_RODADA: begin
        if (r_mais == alvo) begin
          state_next = FIM_GANHOU;
        end else if (modo_reg) begin
          state_next = ESCREVE;
        end else begin
          r_next     = r_reg + WP'(1);
          e_next     = '0;
          state_next = MOSTRA;
        end
      end
      ESCREVE: begin
        leds = botoes;
        if (valid) begin
          if ($onehot(botoes)) begin
            we         = 1'b1;
            waddr      = r_reg + WP'(1);
            wdata      = botoes;
            r_next     = r_reg + WP'(1);
            e_next     = '0;
            state_next = MOSTRA;
          end else begin
            state_next = FIM_PERDEU;
          end
        end else if (timer_fim) begin
          state_next = FIM_TIMEOUT;
        end
      end
      default: state_next = INICIAL;
    endcase
  end

  // Both counters restart whenever their state is (re-)entered.
  always_comb begin
    timer_next = '0;
    if ((state_reg == ESPERA || state_reg == ESCREVE) && state_next == state_reg)
      timer_next = ignora_timeout ? timer_reg : timer_reg + TW'(1);
  end

  always_comb begin
    led_cnt_next = '0;
    if ((state_reg == MOSTRA || state_reg == PAUSA) && state_next == state_reg)
      led_cnt_next = led_cnt_reg + LW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= INICIAL;
      r_reg       <= '0;
      e_reg       <= '0;
      g_reg       <= '0;
      lfsr_reg    <= SEMENTE_PADRAO;
      nivel_reg   <= '0;
      modo_reg    <= 1'b0;
      timer_reg   <= '0;
      led_cnt_reg <= '0;
      ant_reg     <= 1'b0;
      move_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      r_reg       <= r_next;
      e_reg       <= e_next;
      g_reg       <= g_next;
      lfsr_reg    <= lfsr_next;
      nivel_reg   <= nivel_next;
      modo_reg    <= modo_next;
      timer_reg   <= timer_next;
      led_cnt_reg <= led_cnt_next;
      ant_reg     <= |botoes;
      if (valid) move_reg <= botoes;
    end
  end

  logic entra_ganhou, entra_perda;
  assign entra_ganhou = (state_next == FIM_GANHOU) && (state_reg != FIM_GANHOU);
  assign entra_perda  = ((state_next == FIM_PERDEU) || (state_next == FIM_TIMEOUT)) &&
                        (state_reg != state_next);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vitorias_reg <= '0;
      derrotas_reg <= '0;
    end else if (zera_placar) begin
      vitorias_reg <= '0;
      derrotas_reg <= '0;
    end else begin
      if (entra_ganhou && vitorias_reg != '1) vitorias_reg <= vitorias_reg + W_PLACAR'(1);
      if (entra_perda  && derrotas_reg != '1) derrotas_reg <= derrotas_reg + W_PLACAR'(1);
    end
  end

  assign ganhou      = (state_reg == FIM_GANHOU);
  assign perdeu      = (state_reg == FIM_PERDEU) || (state_reg == FIM_TIMEOUT);
  assign timeout     = (state_reg == FIM_TIMEOUT);
  assign pronto      = ganhou || perdeu;
  assign vitorias    = vitorias_reg;
  assign derrotas    = derrotas_reg;
  assign db_estado   = state_reg;
  assign db_rodada   = r_reg;
  assign db_esperado = esperado;

endmodule

// File: tb/tb_playseq_jogo_param.sv
// Randomised game sessions against a sequence/scoreboard model derived from the game rules.
module tb_playseq_jogo_param;

  localparam int N  = 4;
  localparam int P  = 4;
  localparam int TT = 20;
  localparam int TL = 2;
  localparam int W  = 4;
  localparam int SAT = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset, jogar, modo_escrita, ignora_timeout, zera_placar;
  logic [N-1:0] botoes;
  logic [1:0]   nivel;
  logic [15:0]  semente;
  logic [N-1:0] leds, db_esperado;
  logic         ganhou, perdeu, timeout, pronto;
  logic [W-1:0] vitorias, derrotas;
  logic [4:0]   db_estado;
  logic [1:0]   db_rodada;

  int n_cmp = 0;
  int n_bad = 0;
  int vit_m = 0;
  int der_m = 0;
  int seq [P];

  playseq_jogo_param #(
    .N_BOTOES(N), .PROF(P), .T_TIMEOUT(TT), .T_LED(TL), .W_PLACAR(W)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes), .nivel(nivel),
    .modo_escrita(modo_escrita), .ignora_timeout(ignora_timeout), .semente(semente),
    .zera_placar(zera_placar), .leds(leds), .ganhou(ganhou), .perdeu(perdeu),
    .timeout(timeout), .pronto(pronto), .vitorias(vitorias), .derrotas(derrotas),
    .db_estado(db_estado), .db_rodada(db_rodada), .db_esperado(db_esperado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1 as a right-shifting register.
  function automatic int lfsr_next(input int s);
    int fb;
    fb = ((s >> 0) ^ (s >> (16 - 14)) ^ (s >> (16 - 13)) ^ (s >> (16 - 11))) & 1;
    return (s >> 1) | (fb << 15);
  endfunction

  task automatic wait_st(input int code);
    int k;
    k = 0;
    while (db_estado != 5'(code) && k < 300) begin
      @(negedge clock);
      k++;
    end
    if (db_estado != 5'(code)) chk("wait_state", db_estado, code);
  endtask

  task automatic press(input logic [N-1:0] b);
    botoes = b;
    #1 chk("echo", leds, b);
    @(negedge clock);
    botoes = '0;
  endtask

  task automatic fim(input int est, input int g, input int p, input int t);
    chk("estado_fim", db_estado, est);
    chk("ganhou", ganhou, g);
    chk("perdeu", perdeu, p);
    chk("timeout", timeout, t);
    chk("pronto", pronto, 1);
    chk("vitorias", vitorias, vit_m);
    chk("derrotas", derrotas, der_m);
    $display("game end: estado=%0d ganhou=%0d perdeu=%0d timeout=%0d vitorias=%0d derrotas=%0d",
             db_estado, ganhou, perdeu, timeout, vitorias, derrotas);
  endtask

  task automatic lose();
    der_m = (der_m < SAT) ? der_m + 1 : SAT;
  endtask

  task automatic start_game(input int nv, input bit md);
    logic [15:0] sd;
    int s;
    sd = 16'($urandom);
    if ($urandom_range(0, 7) == 0) sd = 16'd0;
    s = (sd == 16'd0) ? 'hACE1 : int'(sd);
    for (int i = 0; i < P; i++) begin
      seq[i] = 1 << (s % N);
      s = lfsr_next(s);
    end
    @(negedge clock);
    semente = sd; nivel = 2'(nv); modo_escrita = md; jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
    chk("gera", db_estado, 1);
  endtask

  task automatic play_game(input int nv, input bit md, input int bad_r, input int bad_e,
                           input logic [N-1:0] bad_val, input logic [N-1:0] app_val,
                           input bit zera_win);
    int alvo;
    logic [N-1:0] mv;
    alvo = (nv + 1) * P / 4;
    start_game(nv, md);
    for (int r = 0; r < alvo; r++) begin
      for (int e = 0; e <= r; e++) begin
        wait_st(2);
        chk("preview", leds, seq[e]);
        chk("rodada", db_rodada, r);
        wait_st(3);
        chk("gap", leds, 0);
      end
      for (int e = 0; e <= r; e++) begin
        wait_st(4);
        chk("esperado", db_esperado, seq[e]);
        if (r == bad_r && e == bad_e) begin
          mv = bad_val;
          if (mv == N'(seq[e]) || mv == '0) mv = ~N'(seq[e]);
          press(mv);
          wait_st(9);
          lose();
          fim(9, 0, 1, 0);
          return;
        end
        press(N'(seq[e]));
      end
      if (r + 1 == alvo) break;
      if (md) begin
        wait_st(7);
        mv = app_val;
        if (mv == '0) mv = N'(1 << $urandom_range(0, N - 1));
        press(mv);
        if (!$onehot(mv)) begin
          wait_st(9);
          lose();
          fim(9, 0, 1, 0);
          return;
        end
        seq[r + 1] = int'(mv);
      end
    end
    wait_st(6);
    if (zera_win) zera_placar = 1'b1;
    @(negedge clock);
    zera_placar = 1'b0;
    vit_m = zera_win ? 0 : ((vit_m < SAT) ? vit_m + 1 : SAT);
    if (zera_win) der_m = 0;
    fim(8, 1, 0, 0);
  endtask

  task automatic timeout_game(input bit ign);
    start_game(0, 1'b0);
    wait_st(4);
    ignora_timeout = ign;
    if (ign) begin
      repeat (3 * TT) @(negedge clock);
      chk("frozen", db_estado, 4);
      ignora_timeout = 1'b0;
    end
    repeat (TT - 1) @(negedge clock);
    chk("before_timeout", db_estado, 4);
    @(negedge clock);
    lose();
    fim(10, 0, 1, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int nv;
    int br;
    reset = 1'b1; jogar = 1'b0; botoes = '0; nivel = '0; modo_escrita = 1'b0;
    ignora_timeout = 1'b0; semente = '0; zera_placar = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_estado", db_estado, 0);
    chk("rst_leds", leds, 0);
    chk("rst_flags", {ganhou, perdeu, timeout, pronto}, 0);
    chk("rst_vitorias", vitorias, 0);
    chk("rst_derrotas", derrotas, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle", db_estado, 0);

    play_game(3, 1'b0, -1, 0, '0, '0, 1'b0);
    play_game(3, 1'b0, 1, 1, 4'b1000, '0, 1'b0);
    timeout_game(1'b0);
    timeout_game(1'b1);
    play_game(1, 1'b1, -1, 0, '0, 4'b0100, 1'b0);
    play_game(3, 1'b1, -1, 0, '0, 4'b0110, 1'b0);

    for (int i = 0; i < 3; i++) begin
      nv = $urandom_range(0, 3);
      br = $urandom_range(0, nv);
      play_game(nv, 1'($urandom), br, $urandom_range(0, br), N'($urandom), '0, 1'b0);
    end
    for (int i = 0; i < 16; i++)
      play_game($urandom_range(0, 3), 1'($urandom), -1, 0, '0, '0, 1'b0);
    chk("saturado", vitorias, SAT);

    play_game(0, 1'b0, -1, 0, '0, '0, 1'b1);

    start_game(3, 1'b0);
    wait_st(2);
    reset = 1'b1;
    #1;
    chk("abort_estado", db_estado, 0);
    chk("abort_leds", leds, 0);
    chk("abort_vitorias", vitorias, 0);
    chk("abort_derrotas", derrotas, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_idle", db_estado, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
